ethernet_rx_filter: RTL and testbench
=====================================

ETHERNET_RX_FILTER -- requirements
Module: ethernet_rx_filter

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01: station address, byte 0 = bits 47:40.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: output buffer entries, power of two, minimum 4.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port frame_ready, input, 1: one-cycle strobe, frame holds a received byte.
REQ-006 SHALL have port frame, input, 8: received byte, valid when frame_ready=1.
REQ-007 SHALL have port frame_end, input, 1: marks the final byte of a frame; sampled only when frame_ready=1.
REQ-008 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-009 SHALL have port out_data, output, 8: FIFO head byte.
REQ-010 SHALL have port out_last, output, 1: head byte is the last byte of a frame.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts head.
REQ-012 SHALL have port overflow, output, 1: sticky; a byte was discarded because the FIFO was full.
REQ-013 SHALL have port frame_count, output, 8: accepted frames, wrapping.
REQ-014 SHALL have port drop_count, output, 8: rejected frames, saturating at 255.

Function
REQ-015 SHALL implement states IDLE, SYNC, ADDR, PASS, DROP; a "byte" below means a cycle with frame_ready=1.
REQ-016 IDLE: byte 0x55 -> SYNC; any other byte ignored, stay IDLE.
REQ-017 SYNC: 0x55 -> stay; 0xD5 -> ADDR, address index cleared to 0; any other byte -> DROP.
REQ-018 ADDR: byte i (0..5) SHALL be compared against MAC_ADDR byte i and against 0xFF; two running flags, unicast-match and broadcast-match, are kept; ADDR bytes SHALL NOT enter the FIFO.
REQ-019 ADDR byte 5: either flag still set -> PASS; otherwise -> DROP with drop_count increment.
REQ-020 PASS: each byte SHALL be pushed as {frame_end, frame}; byte with frame_end=1 -> IDLE and frame_count increment.
REQ-021 DROP: bytes ignored; byte with frame_end=1 -> IDLE.
REQ-022 frame_end=1 on a byte in SYNC or ADDR (runt frame) -> IDLE, drop_count increment, nothing pushed.
REQ-023 frame_end=1 in IDLE SHALL be ignored.
REQ-024 Fullness SHALL be evaluated on the pre-pop count: a push arriving while full is discarded and sets overflow, even when a pop occurs in the same cycle.
REQ-025 A discarded byte with frame_end=1 SHALL still return the FSM to IDLE and increment frame_count; its last marker is lost.
REQ-026 out_valid SHALL equal FIFO not empty; out_data and out_last SHALL be driven from the head entry.
REQ-027 A pop SHALL occur when out_valid and out_ready are both 1; out_ready while empty has no effect.
REQ-028 Push and pop in the same cycle while not full SHALL leave the occupancy unchanged.
REQ-029 Latency: a byte pushed at clock edge N SHALL be visible at the head, if the FIFO was empty, in the cycle after edge N.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-031 drop_count SHALL stay at 255 once reached; frame_count SHALL wrap from 255 to 0.

Reset
REQ-032 reset=0 SHALL immediately set state to IDLE, empty the FIFO, and clear overflow, frame_count, drop_count and the match flags; out_valid SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard any partial frame; the first byte accepted after release is treated as if in IDLE.

Verification
REQ-034 Frame: 7x55, D5, MAC_ADDR bytes, 11 22 33 (33 with frame_end), out_ready=1 -> out stream 11,22,33 with out_last only on 33; frame_count=1.
REQ-035 Same frame with destination FF FF FF FF FF FF -> accepted identically; destination 02 00 00 00 00 02 -> no output, drop_count=1.
REQ-036 55 55 AA, then a valid frame -> first attempt dropped without a count, second frame accepted; 55 D5 02 00 with frame_end on 00 -> drop_count increments.
REQ-037 out_ready=0 with a 20-byte payload -> 16 entries held, overflow=1, and frame_count still 1; then out_ready=1 -> exactly 16 bytes drained, none with out_last.
REQ-038 FIFO full with a push and a pop in the same cycle -> pushed byte discarded, occupancy 15, overflow=1.
REQ-039 reset pulsed low after the third payload byte -> out_valid=0 asynchronously, all counters 0, and the next complete frame is accepted.

Source files
------------

// File: rtl/ethernet_rx_filter.sv
// Ethernet receive filter.
// Locks onto the preamble and start-of-frame delimiter, then checks the
// destination address for a unicast or broadcast match. Payload bytes of
// accepted frames are buffered in a FIFO, each with its end-of-frame marker.
// Accepted and rejected frames are counted.
module ethernet_rx_filter #(
    parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_ready,
    input  logic [7:0] frame,
    input  logic       frame_end,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] frame_count,
    output logic [7:0] drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ADDR,
        PASS,
        DROP
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  addr_idx, addr_idx_nx;
    logic        uni_match, uni_match_nx;
    logic        bc_match, bc_match_nx;
    logic [7:0]  mac_byte;
    logic        uni_hit, bc_hit;
    logic        push_req;
    logic        count_frame;
    logic        count_drop;

    logic [8:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_count;
    logic        fifo_full, fifo_empty;
    logic        push_ok, pop;

    // Select the station address byte expected at the current address index.
    always_comb begin
        mac_byte = '0;
        case (addr_idx)
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = '0;
        endcase
    end

    assign uni_hit = uni_match & (frame == mac_byte);
    assign bc_hit  = bc_match  & (frame == 8'hFF);

    // Next-state logic: frame parsing, address matching and event strobes.
    always_comb begin
        state_nx     = state;
        addr_idx_nx  = addr_idx;
        uni_match_nx = uni_match;
        bc_match_nx  = bc_match;
        push_req     = 1'b0;
        count_frame  = 1'b0;
        count_drop   = 1'b0;
        if (frame_ready) begin
            case (state)
                IDLE: begin
                    if (frame == 8'h55) begin
                        state_nx = SYNC;
                    end
                end
                SYNC: begin
                    if (frame_end) begin
                        state_nx   = IDLE;
                        count_drop = 1'b1;
                    end else if (frame == 8'h55) begin
                        state_nx = SYNC;
                    end else if (frame == 8'hD5) begin
                        state_nx     = ADDR;
                        addr_idx_nx  = '0;
                        uni_match_nx = 1'b1;
                        bc_match_nx  = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
                ADDR: begin
                    if (frame_end) begin
                        state_nx   = IDLE;
                        count_drop = 1'b1;
                    end else begin
                        uni_match_nx = uni_hit;
                        bc_match_nx  = bc_hit;
                        if (addr_idx == 3'd5) begin
                            if (uni_hit || bc_hit) begin
                                state_nx = PASS;
                            end else begin
                                state_nx   = DROP;
                                count_drop = 1'b1;
                            end
                        end else begin
                            addr_idx_nx = addr_idx + 3'd1;
                        end
                    end
                end
                PASS: begin
                    push_req = 1'b1;
                    if (frame_end) begin
                        state_nx    = IDLE;
                        count_frame = 1'b1;
                    end
                end
                DROP: begin
                    if (frame_end) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // FSM state, address index and match flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_idx  <= '0;
            uni_match <= 1'b0;
            bc_match  <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_idx  <= addr_idx_nx;
            uni_match <= uni_match_nx;
            bc_match  <= bc_match_nx;
        end
    end

    // Fullness uses the pre-pop occupancy, so a pop never frees room for a
    // push in the same cycle.
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push_ok    = push_req & ~fifo_full;
    assign pop        = ~fifo_empty & out_ready;

    // FIFO storage; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {frame_end, frame};
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = mem[rd_ptr][7:0];
    assign out_last  = mem[rd_ptr][8];

    // Status: sticky overflow, wrapping frame counter, saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end
            if (count_frame) begin
                frame_count <= frame_count + 8'd1;
            end
            if (count_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ethernet_rx_filter.sv
// Self-checking bench for ethernet_rx_filter: table of whole frames with
// expected output streams and counters, plus hand-written corner sequences.
module tb_ethernet_rx_filter;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam int          DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_ready = 1'b0;
    logic [7:0] frame = 8'h00;
    logic       frame_end = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       overflow;
    logic [7:0] frame_count;
    logic [7:0] drop_count;

    int checks = 0;
    int passed = 0;

    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];

    typedef struct {
        logic [47:0] dst;
        int          npre;
        int          n;
        logic [7:0]  base;
        bit          accept;
        logic [7:0]  fc;
        logic [7:0]  dc;
    } fvec_t;

    fvec_t vecs[6];

    ethernet_rx_filter #(
        .MAC_ADDR  (MAC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_ready(frame_ready),
        .frame      (frame),
        .frame_end  (frame_end),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .frame_count(frame_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Record every byte handed over; inputs only change just after posedge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            rx_q.push_back({out_last, out_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay(input logic [7:0] base, input int k);
        return base + 8'(k * 17);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        frame       = b;
        frame_end   = e;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        frame_end   = 1'b0;
    endtask

    task automatic send_header(input logic [47:0] dst, input int npre);
        for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(dst[47-8*i -: 8], 1'b0);
    endtask

    task automatic send_payload(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) send_byte(pay(base, k), k == n - 1);
    endtask

    task automatic expect_payload(input int n, input logic [7:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) exp_q.push_back({(k == n - 1), pay(base, k)});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string name);
        check({name, " count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s byte %0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{MAC,              7, 3, 8'h11, 1'b1, 8'd1, 8'd0};
        vecs[1] = '{48'hFFFFFFFFFFFF, 7, 3, 8'h11, 1'b1, 8'd2, 8'd0};
        vecs[2] = '{48'h020000000002, 7, 3, 8'h11, 1'b0, 8'd2, 8'd1};
        vecs[3] = '{48'hFFFFFFFFFF01, 7, 3, 8'h11, 1'b0, 8'd2, 8'd2};
        vecs[4] = '{48'h120000000001, 7, 3, 8'h11, 1'b0, 8'd2, 8'd3};
        vecs[5] = '{MAC,              1, 1, 8'h5A, 1'b1, 8'd3, 8'd3};

        // Reset state
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset drop_count", 32'(drop_count), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b1;

        // Frame table
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_header(vecs[v].dst, vecs[v].npre);
            send_payload(vecs[v].n, vecs[v].base);
            wait_cycles(6);
            if (vecs[v].accept) expect_payload(vecs[v].n, vecs[v].base, vecs[v].n);
            compare_stream($sformatf("vec%0d stream", v));
            check($sformatf("vec%0d frame_count", v), 32'(frame_count), 32'(vecs[v].fc));
            check($sformatf("vec%0d drop_count", v), 32'(drop_count), 32'(vecs[v].dc));
            check($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
            check($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'd0);
        end

        // Bad delimiter dropped without a count, then a good frame
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        wait_cycles(3);
        check("bad sfd drop_count", 32'(drop_count), 32'd3);
        send_header(MAC, 7);
        send_payload(3, 8'h11);
        wait_cycles(6);
        expect_payload(3, 8'h11, 3);
        compare_stream("after bad sfd stream");
        check("after bad sfd frame_count", 32'(frame_count), 32'd4);

        // Runt ending inside the address field
        send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_cycles(3);
        check("addr runt drop_count", 32'(drop_count), 32'd4);
        check("addr runt no output", 32'(rx_q.size()), 32'd0);

        // frame_end while idle is ignored
        send_byte(8'h00, 1'b1);
        send_header(MAC, 2);
        send_payload(2, 8'h40);
        wait_cycles(6);
        expect_payload(2, 8'h40, 2);
        compare_stream("idle end stream");
        check("idle end frame_count", 32'(frame_count), 32'd5);
        check("idle end drop_count", 32'(drop_count), 32'd4);

        // Runt ending in the preamble
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b1);
        wait_cycles(3);
        check("sync runt drop_count", 32'(drop_count), 32'd5);

        // Overflow with a 20-byte payload held back
        do_reset();
        out_ready = 1'b0;
        send_header(MAC, 7);
        send_payload(20, 8'h01);
        wait_cycles(4);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf frame_count", 32'(frame_count), 32'd1);
        check("ovf drop_count", 32'(drop_count), 32'd0);
        check("ovf out_valid", 32'(out_valid), 32'd1);
        rx_q.delete();
        out_ready = 1'b1;
        wait_cycles(DEPTH + 6);
        expect_payload(20, 8'h01, DEPTH);
        compare_stream("ovf drain");
        check("ovf drained out_valid", 32'(out_valid), 32'd0);

        // Push and pop together while full
        do_reset();
        out_ready = 1'b0;
        send_header(MAC, 7);
        send_payload(DEPTH, 8'h30);
        wait_cycles(3);
        check("full overflow before", 32'(overflow), 32'd0);
        check("full frame_count", 32'(frame_count), 32'd1);
        send_header(MAC, 7);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        frame       = 8'hEE;
        frame_end   = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        frame_end   = 1'b0;
        out_ready   = 1'b0;
        wait_cycles(2);
        check("full overflow after", 32'(overflow), 32'd1);
        check("full discarded end frame_count", 32'(frame_count), 32'd2);
        exp_q.push_back({1'b0, pay(8'h30, 0)});
        compare_stream("full same-cycle pop");
        out_ready = 1'b1;
        wait_cycles(DEPTH + 6);
        for (int k = 1; k < DEPTH; k++) exp_q.push_back({(k == DEPTH - 1), pay(8'h30, k)});
        compare_stream("full remaining");

        // Asynchronous reset mid-frame
        out_ready = 1'b0;
        send_header(MAC, 7);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset frame_count", 32'(frame_count), 32'd0);
        check("async reset drop_count", 32'(drop_count), 32'd0);
        check("async reset overflow", 32'(overflow), 32'd0);
        #1;
        reset = 1'b1;
        rx_q.delete();
        out_ready = 1'b1;
        send_header(MAC, 7);
        send_payload(3, 8'h11);
        wait_cycles(6);
        expect_payload(3, 8'h11, 3);
        compare_stream("post reset stream");
        check("post reset frame_count", 32'(frame_count), 32'd1);

        // drop_count saturation
        for (int i = 0; i < 255; i++) begin
            send_byte(8'h55, 1'b0);
            send_byte(8'h55, 1'b1);
        end
        wait_cycles(2);
        check("drop_count at 255", 32'(drop_count), 32'd255);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h55, 1'b0);
            send_byte(8'h55, 1'b1);
        end
        wait_cycles(2);
        check("drop_count saturated", 32'(drop_count), 32'd255);

        // frame_count wrap
        for (int i = 0; i < 254; i++) begin
            send_header(MAC, 1);
            send_payload(1, 8'h77);
        end
        wait_cycles(2);
        check("frame_count at 255", 32'(frame_count), 32'd255);
        send_header(MAC, 1);
        send_payload(1, 8'h77);
        wait_cycles(2);
        check("frame_count wrapped", 32'(frame_count), 32'd0);
        check("wrap overflow", 32'(overflow), 32'd0);
        rx_q.delete();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
